// File: rtl/or_flags_pkg.sv
// rtl/or_flags_pkg.sv - shared constants for the or_flags_n sticky flag combiner
package or_flags_pkg;

    localparam int OR_FLAGS_N_DEF = 8;
    localparam int OR_FLAGS_N_MAX = 32;

    // Values for the EDGE parameter
    localparam int MODO_NIVEL  = 0;
    localparam int MODO_FLANCO = 1;

endpackage

// File: rtl/or_flags_n_detector_flanco.sv
// rtl/or_flags_n_detector_flanco.sv - per-channel optional synchroniser and event detector
// OR_FLAGS_SYNC_EN adds a 2-flop synchroniser ahead of detection.
module detector_flanco
    import or_flags_pkg::*;
#(
    parameter int EDGE = MODO_FLANCO
) (
    input  logic clk,
    input  logic reset,
    input  logic dato,
    output logic evento
);

    logic dato_s;
    logic dato_q;

`ifdef OR_FLAGS_SYNC_EN
    logic [1:0] sinc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sinc <= 2'b11;
        end else begin
            sinc <= {sinc[0], dato};
        end
    end

    assign dato_s = sinc[1];
`else
    assign dato_s = dato;
`endif

    // Previous sample resets high so an input already asserted at release is not an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dato_q <= 1'b1;
        end else begin
            dato_q <= dato_s;
        end
    end

    assign evento = dato_s & ((EDGE == MODO_FLANCO) ? ~dato_q : 1'b1);

endmodule

// File: rtl/or_flags_n.sv
// rtl/or_flags_n.sv - N-channel sticky OR combiner with W1C flags, masked request and pulse
// Optional OR_FLAGS_SYNC_EN synchronises datos before event detection.
module or_flags_n
    import or_flags_pkg::*;
#(
    parameter int N    = OR_FLAGS_N_DEF,
    parameter int EDGE = MODO_FLANCO
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] datos,
    input  logic [N-1:0] mascara,
    input  logic [N-1:0] limpiar,
    output logic [N-1:0] pendientes,
    output logic         salida,
    output logic         salida_pulso
);

    logic [N-1:0] evento;
    logic         peticion;

    for (genvar i = 0; i < N; i++) begin : g_canal
        detector_flanco #(.EDGE(EDGE)) u_det (
            .clk    (clk),
            .reset  (reset),
            .dato   (datos[i]),
            .evento (evento[i])
        );
    end

    // Set wins over a simultaneous clear so no event is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendientes <= '0;
        end else begin
            pendientes <= (pendientes & ~limpiar) | evento;
        end
    end

    assign peticion = |(pendientes & mascara);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            salida       <= 1'b0;
            salida_pulso <= 1'b0;
        end else begin
            salida       <= peticion;
            salida_pulso <= peticion & ~salida;
        end
    end

endmodule

// File: tb/tb_or_flags_n.sv
// tb/tb_or_flags_n.sv - scoreboard bench for or_flags_n in edge and level modes
module tb_or_flags_n;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] da = 8'hFF, ma = 8'hFF, la = 8'h00;
    logic [7:0] db = 8'h00, mb = 8'hFF, lb = 8'h00;
    logic [7:0] pa, pb;
    logic       sa, spa, sb, spb;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         sel;
        logic [7:0] p;
        logic       s;
        logic       pu;
        string      name;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    or_flags_n #(.N(8), .EDGE(1)) dut_a (
        .clk(clk), .reset(reset), .datos(da), .mascara(ma), .limpiar(la),
        .pendientes(pa), .salida(sa), .salida_pulso(spa)
    );

    or_flags_n #(.N(8), .EDGE(0)) dut_b (
        .clk(clk), .reset(reset), .datos(db), .mascara(mb), .limpiar(lb),
        .pendientes(pb), .salida(sb), .salida_pulso(spb)
    );

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle, compared at the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                if (!e.sel) begin
                    chk8({e.name, ".pend"}, pa, e.p);
                    chk1({e.name, ".sal"}, sa, e.s);
                    chk1({e.name, ".pulso"}, spa, e.pu);
                end else begin
                    chk8({e.name, ".pend"}, pb, e.p);
                    chk1({e.name, ".sal"}, sb, e.s);
                    chk1({e.name, ".pulso"}, spb, e.pu);
                end
            end
        end
    end

    // Apply inputs, take one edge, queue the state expected after that edge
    task automatic cyc(input bit sel, input logic [7:0] d, input logic [7:0] m,
                       input logic [7:0] l, input logic [7:0] ep, input logic es,
                       input logic epu, input string name);
        exp_t e;
        if (!sel) begin da = d; ma = m; la = l; end
        else      begin db = d; mb = m; lb = l; end
        @(posedge clk);
        e.sel = sel; e.p = ep; e.s = es; e.pu = epu; e.name = name;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Reset held with all inputs high
        cyc(0, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0, "rst0");
        cyc(0, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0, "rst1");
        reset = 1'b0;
        for (int i = 0; i < 5; i++)
            cyc(0, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0, "hold_ff");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "drop");

        // Single pulse on channel 3
        cyc(0, 8'h08, 8'hFF, 8'h00, 8'h08, 0, 0, "ev3_t");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h08, 1, 1, "ev3_t1");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h08, 1, 0, "ev3_t2");

        // New rising edge with simultaneous clear: set wins, no new pulse
        cyc(0, 8'h08, 8'hFF, 8'h08, 8'h08, 1, 0, "setwins");
        cyc(0, 8'h00, 8'hFF, 8'h08, 8'h00, 1, 0, "clr3");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "clr3_out");

        // Masked channel still latches, unmask drives salida next edge
        cyc(0, 8'h08, 8'hF7, 8'h00, 8'h08, 0, 0, "mask_t");
        cyc(0, 8'h00, 8'hF7, 8'h00, 8'h08, 0, 0, "mask_t1");
        cyc(0, 8'h00, 8'hF7, 8'h00, 8'h08, 0, 0, "mask_t2");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h08, 1, 1, "unmask");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h08, 1, 0, "unmask2");
        cyc(0, 8'h00, 8'hFF, 8'h08, 8'h00, 1, 0, "clr3b");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "idle");

        // Channels 0 and 5, cleared independently
        cyc(0, 8'h21, 8'hFF, 8'h00, 8'h21, 0, 0, "ev05");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h21, 1, 1, "ev05_t1");
        cyc(0, 8'h00, 8'hFF, 8'h01, 8'h20, 1, 0, "clr0");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h20, 1, 0, "keep5");
        cyc(0, 8'h00, 8'hFF, 8'h20, 8'h00, 1, 0, "clr5");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "clr5_out");

        // Held-high input gives a single event and must fall to re-arm
        cyc(0, 8'h04, 8'hFF, 8'h00, 8'h04, 0, 0, "hold_t");
        cyc(0, 8'h04, 8'hFF, 8'h00, 8'h04, 1, 1, "hold_t1");
        cyc(0, 8'h04, 8'hFF, 8'h04, 8'h00, 1, 0, "hold_clr");
        cyc(0, 8'h04, 8'hFF, 8'h00, 8'h00, 0, 0, "hold_norearm");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "hold_fall");
        cyc(0, 8'h04, 8'hFF, 8'h00, 8'h04, 0, 0, "rearm");
        cyc(0, 8'h04, 8'hFF, 8'h00, 8'h04, 1, 1, "rearm_t1");

        // Asynchronous reset mid-operation
        #2 reset = 1'b1;
        #1;
        chk8("async.pend", pa, 8'h00);
        chk1("async.sal", sa, 1'b0);
        chk1("async.pulso", spa, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 8'h04, 8'hFF, 8'h00, 8'h00, 0, 0, "post_rst_high");
        cyc(0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "post_rst_low");

        // Level mode: clear cannot beat an input that is still high
        cyc(1, 8'h02, 8'hFF, 8'h00, 8'h02, 0, 0, "lvl_set");
        cyc(1, 8'h02, 8'hFF, 8'h02, 8'h02, 1, 1, "lvl_clr_held");
        cyc(1, 8'h02, 8'hFF, 8'h02, 8'h02, 1, 0, "lvl_clr_held2");
        cyc(1, 8'h00, 8'hFF, 8'h02, 8'h00, 1, 0, "lvl_clr");
        cyc(1, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "lvl_idle");

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/or_flags_n.md
# or_flags_n

Parametrised N-channel sticky OR combiner for the RTC flag/interrupt path. Each input channel (alarm, timer, second tick, etc.) is edge- or level-detected and latched into a per-channel pending flag. Pending flags are masked and OR-reduced into one registered request line plus a one-cycle pulse. Flags are cleared per channel by write-1-to-clear. The block replaces ad-hoc two-input OR gates feeding the controller.

## Interface
- N, 8: number of input channels (1..32).
- EDGE, 1: 1 = a rising edge of datos[i] sets pending; 0 = datos[i] high sets pending every cycle (level mode).
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- datos  input  N  raw event inputs, one per channel.
- mascara  input  N  1 = channel enabled into salida; does not affect latching.
- limpiar  input  N  write-1-to-clear strobe per channel, sampled each clk edge.
- pendientes  output  N  registered pending flags (unmasked).
- salida  output  1  registered OR of (pendientes & mascara).
- salida_pulso  output  1  one-cycle pulse when salida goes 0 -> 1.

## Operation
- Reset values: pendientes = 0, salida = 0, salida_pulso = 0, internal previous-sample register datos_q = all ones (an input already high at reset release is not an event in EDGE mode).
- Event per channel: EDGE=1: evento[i] = datos[i] & ~datos_q[i]; EDGE=0: evento[i] = datos[i]. datos_q <= datos every edge.
- Pending update each edge: pendientes[i] <= (pendientes[i] & ~limpiar[i]) | evento[i].
- Simultaneous evento[i] and limpiar[i] in the same cycle: set wins; the flag stays 1 (no lost event).
- limpiar on a channel that is not pending: no effect. Each channel is independent.
- salida <= |(pendientes & mascara), computed from the already-registered pendientes (one-register pipeline).
- salida_pulso <= |(pendientes & mascara) & ~salida; high for exactly one cycle per 0 -> 1 transition of salida.
- Mask changes take effect on salida at the next edge. Masked channels still latch.
- A channel held high in EDGE mode produces a single event. It must return low and rise again to re-arm.

## Timing
- datos[i] rises before edge t: pendientes[i] = 1 after edge t; salida and salida_pulso = 1 after edge t+1. Latency is 2 edges.
- limpiar[i] at edge t (no new event): pendientes[i] = 0 after t; salida falls after t+1 if no other enabled flag remains.
- Reset asserted mid-operation: all outputs go to reset values asynchronously. The first event detection occurs at the first edge after deassertion.
- There is no backpressure or handshake beyond limpiar. The consumer clears flags by pulsing limpiar for at least one cycle.

## Configuration
- OR_FLAGS_SYNC_EN defined: a 2-flop synchroniser per channel is placed on datos before event detection. Synchroniser flops reset to 1. Latency datos -> pendientes grows by 2 edges (datos -> salida becomes 4).
- OR_FLAGS_SYNC_EN undefined: datos is used directly. Inputs must be synchronous to clk.

## Structure
- Shared package or_flags_pkg contains:
  - OR_FLAGS_N_DEF = 8 and OR_FLAGS_N_MAX = 32.
  - Mode constants MODO_NIVEL = 0 and MODO_FLANCO = 1 for EDGE.
- One sub-module, detector_flanco:
  - Per-channel optional synchroniser, previous-sample flop and evento generation.
  - Instantiated N times via generate.
- The top level holds the pending register, the mask/OR reduction and the pulse logic.

## Test plan
- Reset with datos = 8'hFF, release, hold for 5 cycles -> pendientes = 0, salida = 0 (EDGE=1, no spurious event).
- Pulse datos[3] for 1 cycle, mascara = 8'hFF -> pendientes = 8'h08 after edge t, salida = 1 and salida_pulso = 1 for one cycle at t+1; salida stays 1.
- mascara = 8'hF7, event on channel 3 -> pendientes = 8'h08, salida stays 0. Then set mascara = 8'hFF -> salida = 1 at the next edge.
- limpiar[3] in the same cycle as a new datos[3] rising edge -> pendientes[3] remains 1, salida remains 1, no new pulse.
- Events on channels 0 and 5, clear channel 0 only -> pendientes = 8'h20, salida stays 1. Clear channel 5 -> pendientes = 0, salida = 0 one edge later.
- EDGE=0, datos[1] held high, limpiar[1] asserted -> pendientes[1] stays 1. Drop datos[1], clear -> pendientes[1] = 0.
